// File: rtl/maxnet_if.sv
// Handshake and data bundle for the maxnet_n winner-take-all engine.
// Widths derive from the same parameters that are given to the engine.
interface maxnet_if #(
  parameter int N        = 4,
  parameter int W        = 5,
  parameter int WW       = 6,
  parameter int MAX_ITER = 15
);
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(MAX_ITER + 1);

  logic            start;
  logic [N*W-1:0]  x;
  logic [WW-1:0]   w1;
  logic [WW-1:0]   w2;
  logic            done;
  logic            busy;
  logic [W-1:0]    max;
  logic [XW-1:0]   winner;
  logic            winner_valid;
  logic            timeout;
  logic [IW-1:0]   iter_count;

  modport master (
    output start, x, w1, w2,
    input  done, busy, max, winner, winner_valid, timeout, iter_count
  );

  modport slave (
    input  start, x, w1, w2,
    output done, busy, max, winner, winner_valid, timeout, iter_count
  );
endinterface

// File: rtl/maxnet_n.sv
// Iterative Maxnet lateral-inhibition engine: N channels share one update
// datapath, one channel per cycle, with an iteration cap and timeout flag.
module maxnet_n #(
  parameter int N        = 4,
  parameter int W        = 5,
  parameter int WW       = 6,
  parameter int FRAC     = 4,
  parameter int MAX_ITER = 15
) (
  input  logic     clk,
  input  logic     rst,
  maxnet_if.slave  bus
);
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int XW  = CW;
  localparam int SW  = W + CW;
  localparam int TW  = SW + WW + 1;
  localparam int IW  = $clog2(MAX_ITER + 1);
  localparam int NZW = CW + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SUM    = 3'd1,
    ST_UPDATE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t          state_r, next_s;
  logic [CW-1:0]   c_r;
  logic [SW-1:0]   sum_r;
  logic [W-1:0]    act_r  [N];
  logic [W-1:0]    orig_r [N];
  logic [WW-1:0]   w1_r, w2_r;
  logic [IW-1:0]   iter_r;
  logic            done_r, busy_r, valid_r, timeout_r;
  logic [W-1:0]    max_r;
  logic [XW-1:0]   winner_r;

  logic [W-1:0]    cur_s;
  logic [TW-1:0]   p_self_s, p_inh_s, t_s, shifted_s;
  logic [W-1:0]    upd_s;
  logic [NZW-1:0]  nz_s;
  logic [XW-1:0]   best_s;
  logic [W-1:0]    best_val_s;
  logic [IW-1:0]   iter_next_s;
  logic            last_c_s;

  assign bus.done         = done_r;
  assign bus.busy         = busy_r;
  assign bus.max          = max_r;
  assign bus.winner       = winner_r;
  assign bus.winner_valid = valid_r;
  assign bus.timeout      = timeout_r;
  assign bus.iter_count   = iter_r;

  // Shared update datapath: S is the frozen pre-iteration sum, so S - act[c]
  // is the inhibition from all other channels even while act[] updates in place.
  always_comb begin
    cur_s     = act_r[c_r];
    p_self_s  = TW'(w1_r) * TW'(cur_s);
    p_inh_s   = TW'(w2_r) * TW'(sum_r - SW'(cur_s));
    t_s       = p_self_s - p_inh_s;
    shifted_s = t_s >> FRAC;
    if (t_s[TW-1]) begin
      upd_s = '0;
    end else if (shifted_s > TW'((2 ** W) - 1)) begin
      upd_s = {W{1'b1}};
    end else begin
      upd_s = shifted_s[W-1:0];
    end
    last_c_s    = (c_r == CW'(N - 1));
    iter_next_s = iter_r + IW'(1);
  end

  // Nonzero count and arg-max (strict compare keeps the lowest index on ties).
  always_comb begin
    nz_s       = '0;
    best_s     = '0;
    best_val_s = '0;
    for (int i = 0; i < N; i++) begin
      if (act_r[i] != '0) begin
        nz_s = nz_s + NZW'(1);
      end else begin
        nz_s = nz_s;
      end
      if (act_r[i] > best_val_s) begin
        best_s     = XW'(i);
        best_val_s = act_r[i];
      end else begin
        best_s     = best_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) next_s = ST_SUM;
        else           next_s = ST_IDLE;
      end
      ST_SUM: begin
        if (last_c_s) next_s = ST_UPDATE;
        else          next_s = ST_SUM;
      end
      ST_UPDATE: begin
        if (last_c_s) next_s = ST_CHECK;
        else          next_s = ST_UPDATE;
      end
      ST_CHECK: begin
        if (nz_s <= NZW'(1))                   next_s = ST_DONE;
        else if (iter_next_s == IW'(MAX_ITER)) next_s = ST_DONE;
        else                                   next_s = ST_SUM;
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State register with registered done/busy derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      done_r  <= (next_s == ST_DONE);
      busy_r  <= (next_s != ST_IDLE);
    end
  end

  // Activation storage, accumulator, counters and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_r       <= '0;
      sum_r     <= '0;
      w1_r      <= '0;
      w2_r      <= '0;
      iter_r    <= '0;
      max_r     <= '0;
      winner_r  <= '0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      for (int i = 0; i < N; i++) begin
        act_r[i]  <= '0;
        orig_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < N; i++) begin
              act_r[i]  <= bus.x[i*W +: W];
              orig_r[i] <= bus.x[i*W +: W];
            end
            w1_r      <= bus.w1;
            w2_r      <= bus.w2;
            c_r       <= '0;
            sum_r     <= '0;
            iter_r    <= '0;
            max_r     <= '0;
            winner_r  <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
          end
        end
        ST_SUM: begin
          sum_r <= sum_r + SW'(cur_s);
          c_r   <= last_c_s ? '0 : c_r + CW'(1);
        end
        ST_UPDATE: begin
          act_r[c_r] <= upd_s;
          c_r        <= last_c_s ? '0 : c_r + CW'(1);
        end
        ST_CHECK: begin
          iter_r <= iter_next_s;
          c_r    <= '0;
          sum_r  <= '0;
          if ((nz_s <= NZW'(1)) || (iter_next_s == IW'(MAX_ITER))) begin
            winner_r  <= best_s;
            max_r     <= (nz_s == '0) ? '0 : orig_r[best_s];
            valid_r   <= (nz_s == NZW'(1));
            timeout_r <= (nz_s > NZW'(1));
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: doc/maxnet_n.md
# maxnet_n

Parametrised iterative Maxnet (lateral-inhibition winner-take-all) engine for N channels of W-bit activations with programmable fixed-point self and inhibition weights. It replaces the fixed 4-input, 5-bit Maxnet top-level. It keeps the start/done handshake and adds channel count, word width, weight precision, an iteration cap with timeout, and winner index/validity outputs. One shared update datapath is time-multiplexed over the channels.

## Interface
- N, 4: channel count, ≥2
- W, 5: activation width (unsigned)
- WW, 6: weight width (unsigned)
- FRAC, 4: weight fractional bits; weight value = w/2^FRAC
- MAX_ITER, 15: iteration cap, ≥1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin run; sampled only in IDLE
- x  in  N*W  input activations; channel i at x[i*W +: W]
- w1  in  WW  self-excitation weight
- w2  in  WW  inhibition weight
- done  out  1  one-cycle pulse when results are valid
- busy  out  1  high in every state except IDLE
- max  out  W  original input value of the winning channel
- winner  out  max(1,clog2(N))  winning channel index
- winner_valid  out  1  exactly one nonzero activation at termination
- timeout  out  1  run ended by reaching MAX_ITER
- iter_count  out  clog2(MAX_ITER+1)  iterations executed in the last run

## Operation
- States: IDLE, SUM, UPDATE, CHECK, DONE.
- IDLE: on start=1, capture x into orig[] and act[], capture w1 and w2, clear iter_count, winner_valid, timeout, winner and max, then go to SUM.
- SUM: N cycles. Channel counter c runs 0..N-1 and accumulates S = Σ act[c] (width W+clog2(N)).
- UPDATE: N cycles, one channel per cycle. Compute t = w1·act[c] − w2·(S − act[c]) as a signed value, width W+clog2(N)+WW+1.
  - If t<0: act[c]=0.
  - Otherwise: act[c] = t>>FRAC (floor), saturated to 2^W−1.
  - S stays frozen during UPDATE, so in-place updates are correct.
- CHECK: 1 cycle. Increment iter_count and compute nz = count of nonzero act[].
  - If nz≤1: go to DONE. winner_valid=(nz==1), winner = index of the nonzero channel (0 if nz==0), max = orig[winner] (0 if nz==0), timeout=0.
  - Else if iter_count (after increment) == MAX_ITER: go to DONE with timeout=1 and winner_valid=0. winner = index of the largest act[], lowest index on tie. max = orig[winner].
  - Else: go to SUM.
- DONE: 1 cycle with done=1, then IDLE. start is ignored in DONE.
- Result outputs hold until the next accepted start.
- start while busy is ignored; it causes no restart and no queueing.
- Reset, including mid-run: state=IDLE. All outputs, act[], orig[], S and counters go to 0.

## Timing
- Reset values: done=0, busy=0, max=0, winner=0, winner_valid=0, timeout=0, iter_count=0.
- Start accepted at edge E0. busy is high from E0+1 through the DONE cycle.
- One iteration takes 2N+1 cycles. A run of k iterations raises done for the single cycle after edge E0+k(2N+1).
- Results are valid in the same cycle as done.
- x, w1 and w2 may change freely after E0.
- A new start is accepted no earlier than the first IDLE cycle after DONE.

## Test plan
All tests use N=4, W=5, WW=6, FRAC=4, MAX_ITER=15 unless stated.
- Normal convergence: x={10,8,3,1} (ch0..3), w1=16, w2=3.
  - Activations after each iteration: {7,5,0,0}, {6,3,0,0}, {5,1,0,0}, {4,0,0,0}.
  - Required: done 36 cycles after start, winner=0, max=10, winner_valid=1, timeout=0, iter_count=4.
- Tie collapse: x={7,7,0,0}, w1=16, w2=3.
  - Both channels decay 5,4,3,2,1,0 together.
  - Required: done at 54 cycles, winner_valid=0, winner=0, max=0, iter_count=6, timeout=0.
- Single nonzero input: x={0,0,9,0}, w1=16, w2=3.
  - Required: done at 9 cycles, winner=2, max=9, winner_valid=1, iter_count=1.
- Timeout with MAX_ITER=2, using the vector from the normal-convergence test.
  - Required: done at 18 cycles, timeout=1, winner_valid=0, winner=0, max=10, iter_count=2.
- Saturation: x={20,0,0,0}, w1=32, w2=0.
  - act[0] saturates at 31, not 40.
  - Required: done at 9 cycles, winner=0, max=20, winner_valid=1.
- Handshake and reset:
  - Pulse start again at cycle 5 of the normal-convergence run: ignored, and done still arrives at 36.
  - Assert rst at cycle 20 of a run: all outputs 0 on the following sample, busy=0.
  - A fresh start then reproduces the normal-convergence results exactly.
